mac_seq: RTL and testbench
==========================

// Module: mac_seq
// PURPOSE
//  Upstream sequencer for one mac unit: on start, reads len img/weight pairs from two sync RAMs,
//  drives rst_mem/mul_mem_en/ac_mem_en with the mac's 2-stage pipeline skew, captures the final
//  accumulator value and presents it downstream on a valid/ready handshake. One dot product per start.
// PARAMETERS
//  IN_WIDTH    8   pixel/weight width (matches mac)
//  OUT_WIDTH   22  accumulator/result width (matches mac)
//  ADDR_WIDTH  10  RAM address width
//  LEN_WIDTH   7   length field width; len 1..2**LEN_WIDTH-1
// PORTS
//  clk         in   1           clock
//  rst         in   1           synchronous, active-high reset
//  start       in   1           begin a dot product (sampled in IDLE only)
//  len         in   LEN_WIDTH   number of products; latched on accepted start
//  img_base    in   ADDR_WIDTH  first image address; latched on accepted start
//  wgt_base    in   ADDR_WIDTH  first weight address; latched on accepted start
//  busy        out  1           high in every state except IDLE
//  mem_rd_en   out  1           RAM read strobe; data returned next cycle
//  img_addr    out  ADDR_WIDTH  image RAM address
//  wgt_addr    out  ADDR_WIDTH  weight RAM address
//  rst_mem     out  1           mac clear
//  mul_mem_en  out  1           mac product-register enable
//  ac_mem_en   out  1           mac accumulate enable
//  mac_out     in   OUT_WIDTH   mac accumulator value
//  res_data    out  OUT_WIDTH   captured result
//  res_valid   out  1           result valid
//  res_ready   in   1           downstream accepts result
// BEHAVIOUR
//  - States: IDLE, CLEAR, RUN, DRAIN, CAPTURE, HOLD. Cycle 0 = cycle start is sampled high in IDLE.
//  - IDLE: start & len!=0 -> CLEAR, latch len/bases. start & len==0: ignored, stay IDLE, no result.
//  - CLEAR (1 cycle): rst_mem=1, cnt<=0 -> RUN.
//  - RUN (len cycles): mem_rd_en=1, img_addr=img_base+cnt, wgt_addr=wgt_base+cnt (mod 2**ADDR_WIDTH,
//    wraps silently); cnt++; after the len-th read -> DRAIN.
//  - Enable skew: 2-deep shift reg on mem_rd_en; mul_mem_en = rd delayed 1, ac_mem_en = rd delayed 2.
//  - DRAIN (2 cycles) -> CAPTURE (1 cycle): res_data<=mac_out -> HOLD.
//  - HOLD: res_valid=1; res_data/res_valid stable while !res_ready; res_ready -> IDLE next cycle.
//    res_ready ignored outside HOLD.
//  - Latency: RUN cycles 2..len+1; last ac_mem_en in cycle len+3; res_valid first high in cycle len+5.
//    Back-to-back: start may be high in the cycle after handshake (IDLE).
//  - start outside IDLE ignored; len/base changes after acceptance have no effect.
//  - Arithmetic: no saturation; len<=64 cannot overflow 22 bits (64*255*255=4161600);
//    larger len wraps mod 2**OUT_WIDTH, as in mac.
//  - rst_mem = rst | (state==CLEAR) (combinational, so mac clears whenever sequencer resets).
//  - Reset (any state, incl. mid-RUN/HOLD): next cycle state=IDLE, busy=0, mem_rd_en=0, addrs=0,
//    mul_mem_en=0, ac_mem_en=0, enable pipe cleared, res_valid=0, res_data=0, cnt=0;
//    in-flight result discarded.
//  - All outputs except rst_mem are registered.
// STRUCTURE
//  - nn_pkg: typedef enum mac_seq_state_t {IDLE,CLEAR,RUN,DRAIN,CAPTURE,HOLD}; IN_WIDTH/OUT_WIDTH
//    defaults; MAC_PIPE_DEPTH=2.
//  - Sub-module en_pipe (DEPTH param, sync reset shift register) for the enable skew; rest inline.
// TESTING (bench instantiates mac_seq + mac + two 1-cycle-latency RAM models)
//  - len=3, img{1,2,3}@0, wgt{4,5,6}@0, res_ready=1 -> res_data=32, res_valid high in cycle 8 only.
//  - len=64, all img/wgt=255 -> res_data=4161600; no overflow.
//  - img_base=1022, len=4 -> img_addr sequence 1022,1023,0,1; correct sum.
//  - res_ready=0 for 10 cycles in HOLD -> res_data/res_valid stable; start pulses ignored, busy=1.
//  - rst mid-RUN (cycle 4, len=8), then start len=2 img{7,7} wgt{3,3} -> result 42, no stale sum.
//  - start with len=0 -> busy stays 0, no rst_mem pulse, no res_valid.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and constants for the mac sequencer and its mac datapath.
package nn_pkg;
  localparam int IN_WIDTH       = 8;
  localparam int OUT_WIDTH      = 22;
  localparam int MAC_PIPE_DEPTH = 2;

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, CAPTURE, HOLD} mac_seq_state_t;
endpackage

// File: rtl/en_pipe.sv
// Enable skew shift register: q[i] is d delayed by i cycles, cleared on reset.
module en_pipe #(
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           d,
  output logic [DEPTH:1] q
);
  logic [DEPTH:0] vld_pipe;

  assign vld_pipe[0] = d;

  always_ff @(posedge clk) begin
    if (rst) vld_pipe[DEPTH:1] <= '0;
    else     vld_pipe[DEPTH:1] <= vld_pipe[DEPTH-1:0];
  end

  assign q = vld_pipe[DEPTH:1];
endmodule

// File: rtl/mac_seq.sv
// Sequencer for one mac unit: streams len img/weight pairs from sync RAMs, skews the mac
// enables to its pipeline, captures the accumulator and offers it on a valid/ready port.
module mac_seq #(
  parameter int IN_WIDTH   = nn_pkg::IN_WIDTH,
  parameter int OUT_WIDTH  = nn_pkg::OUT_WIDTH,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [ADDR_WIDTH-1:0] img_base,
  input  logic [ADDR_WIDTH-1:0] wgt_base,
  output logic                  busy,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] img_addr,
  output logic [ADDR_WIDTH-1:0] wgt_addr,
  output logic                  rst_mem,
  output logic                  mul_mem_en,
  output logic                  ac_mem_en,
  input  logic [OUT_WIDTH-1:0]  mac_out,
  output logic [OUT_WIDTH-1:0]  res_data,
  output logic                  res_valid,
  input  logic                  res_ready
);
  import nn_pkg::*;

  if (OUT_WIDTH < 2 * IN_WIDTH) begin : g_bad_width
    $error("mac_seq: OUT_WIDTH too narrow for one product");
  end

  mac_seq_state_t                state, next_state;
  logic [LEN_WIDTH-1:0]          len_q, cnt;
  logic [ADDR_WIDTH-1:0]         img_base_q, wgt_base_q;
  logic [MAC_PIPE_DEPTH:1]       en_q;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start && len != '0) next_state = CLEAR;
      CLEAR:   next_state = RUN;
      RUN:     if (cnt == len_q - LEN_WIDTH'(1)) next_state = DRAIN;
      DRAIN:   if (cnt == LEN_WIDTH'(MAC_PIPE_DEPTH - 1)) next_state = CAPTURE;
      CAPTURE: next_state = HOLD;
      HOLD:    if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      mem_rd_en  <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      img_addr   <= '0;
      wgt_addr   <= '0;
      cnt        <= '0;
      len_q      <= '0;
      img_base_q <= '0;
      wgt_base_q <= '0;
    end else begin
      state     <= next_state;
      busy      <= (next_state != IDLE);
      mem_rd_en <= (next_state == RUN);
      res_valid <= (next_state == HOLD);
      case (state)
        IDLE: if (next_state == CLEAR) begin
          len_q      <= len;
          img_base_q <= img_base;
          wgt_base_q <= wgt_base;
        end
        CLEAR: begin
          cnt      <= '0;
          img_addr <= img_base_q;
          wgt_addr <= wgt_base_q;
        end
        RUN: begin
          // cnt is reused as the drain counter once the reads are done
          if (next_state == DRAIN) cnt <= '0;
          else begin
            cnt      <= cnt + LEN_WIDTH'(1);
            img_addr <= img_addr + ADDR_WIDTH'(1);
            wgt_addr <= wgt_addr + ADDR_WIDTH'(1);
          end
        end
        DRAIN:   cnt <= cnt + LEN_WIDTH'(1);
        CAPTURE: res_data <= mac_out;
        default: ;
      endcase
    end
  end

  en_pipe #(.DEPTH(MAC_PIPE_DEPTH)) u_en_pipe (
    .clk (clk),
    .rst (rst),
    .d   (mem_rd_en),
    .q   (en_q)
  );

  assign mul_mem_en = en_q[1];
  assign ac_mem_en  = en_q[MAC_PIPE_DEPTH];
  assign rst_mem    = rst | (state == CLEAR);
endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq with a mac model and two 1-cycle RAMs; timeline-based reference model.
module tb_mac_seq;
  localparam int IW = 8;
  localparam int OW = 22;
  localparam int AW = 10;
  localparam int LW = 7;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, res_ready = 1'b0;
  logic [LW-1:0] len = '0;
  logic [AW-1:0] img_base = '0, wgt_base = '0;
  logic          busy, mem_rd_en, rst_mem, mul_mem_en, ac_mem_en, res_valid;
  logic [AW-1:0] img_addr, wgt_addr;
  logic [OW-1:0] mac_out, res_data;

  mac_seq #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .img_base(img_base), .wgt_base(wgt_base),
    .busy(busy), .mem_rd_en(mem_rd_en), .img_addr(img_addr), .wgt_addr(wgt_addr),
    .rst_mem(rst_mem), .mul_mem_en(mul_mem_en), .ac_mem_en(ac_mem_en), .mac_out(mac_out),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAMs and mac unit
  logic [IW-1:0]   img_ram [0:(1<<AW)-1];
  logic [IW-1:0]   wgt_ram [0:(1<<AW)-1];
  logic [IW-1:0]   img_q = '0, wgt_q = '0;
  logic [2*IW-1:0] prod = '0;
  logic [OW-1:0]   acc = '0;

  always @(posedge clk) if (mem_rd_en) begin
    img_q <= img_ram[img_addr];
    wgt_q <= wgt_ram[wgt_addr];
  end

  always @(posedge clk) begin
    if (rst_mem) begin
      prod <= '0;
      acc  <= '0;
    end else begin
      if (mul_mem_en) prod <= img_q * wgt_q;
      if (ac_mem_en)  acc  <= acc + OW'(prod);
    end
  end
  assign mac_out = acc;

  int passed = 0, total = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [OW-1:0] dot(input int n, input logic [AW-1:0] ib, input logic [AW-1:0] wb);
    logic [OW-1:0] s;
    logic [AW-1:0] a, b;
    s = '0;
    for (int i = 0; i < n; i++) begin
      a = ib + AW'(i);
      b = wb + AW'(i);
      s = s + OW'(img_ram[a]) * OW'(wgt_ram[b]);
    end
    return s;
  endfunction

  // Reference model: m_k is the cycle number relative to the accepting cycle (cycle 0).
  bit            m_act = 0, m_after_rst = 0, chk_on = 0;
  int            m_k = 0, m_len = 0;
  logic [AW-1:0] m_ib = '0, m_wb = '0;
  logic [OW-1:0] m_exp = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_act = 0;
      m_after_rst = 1;
    end else if (!m_act) begin
      if (start && len != '0) begin
        m_act = 1; m_k = 1; m_len = int'(len);
        m_ib = img_base; m_wb = wgt_base;
        m_exp = dot(m_len, img_base, wgt_base);
        m_after_rst = 0;
      end
    end else if (m_k >= m_len + 5 && res_ready) m_act = 0;
    else m_k++;
  end

  always @(negedge clk) if (chk_on) begin
    bit e_rd, e_mul, e_ac, e_val, e_rm;
    e_rd  = m_act && m_k >= 2 && m_k <= m_len + 1;
    e_mul = m_act && m_k >= 3 && m_k <= m_len + 2;
    e_ac  = m_act && m_k >= 4 && m_k <= m_len + 3;
    e_val = m_act && m_k >= m_len + 5;
    e_rm  = rst || (m_act && m_k == 1);
    chk("busy", busy, m_act);
    chk("mem_rd_en", mem_rd_en, e_rd);
    chk("mul_mem_en", mul_mem_en, e_mul);
    chk("ac_mem_en", ac_mem_en, e_ac);
    chk("res_valid", res_valid, e_val);
    chk("rst_mem", rst_mem, e_rm);
    if (e_rd) begin
      chk("img_addr", img_addr, AW'(m_ib + AW'(m_k - 2)));
      chk("wgt_addr", wgt_addr, AW'(m_wb + AW'(m_k - 2)));
    end
    if (e_val) chk("res_data", res_data, m_exp);
    if (m_after_rst && !m_act) begin
      chk("rst_res_data", res_data, 0);
      chk("rst_img_addr", img_addr, 0);
      chk("rst_wgt_addr", wgt_addr, 0);
    end
  end

  bit            log_en = 0;
  logic [AW-1:0] addr_q[$];
  always @(negedge clk) if (log_en && mem_rd_en) addr_q.push_back(img_addr);

  // Runs one transaction starting in the current (IDLE) cycle; returns at #1 into the next IDLE cycle.
  task automatic run(input int n, input logic [AW-1:0] ib, input logic [AW-1:0] wb, input int hold,
                     input bit rdy_always, output logic [OW-1:0] res, output int first_v, output int nvalid);
    int c0, k;
    bit done;
    start = 1; len = LW'(n); img_base = ib; wgt_base = wb; res_ready = rdy_always; c0 = cyc;
    @(posedge clk); #1;
    start = 0; len = LW'($urandom); img_base = AW'($urandom); wgt_base = AW'($urandom);
    nvalid = 0; first_v = -1; res = '0; done = 0;
    for (int t = 0; t < 400 && !done; t++) begin
      k = cyc - c0;
      if (res_valid) begin
        nvalid++;
        if (first_v < 0) begin first_v = k; res = res_data; end
      end
      if (rdy_always) begin
        if (!busy && first_v >= 0) done = 1;
      end else if (first_v >= 0) done = 1;
      else res_ready = (k < n + 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (!done) begin @(posedge clk); #1; end
    end
    if (!done) chk("timeout", 0, 1);
    if (!rdy_always && done) begin
      res_ready = 0;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        start = 1'($urandom_range(0, 1)); len = LW'($urandom_range(1, 127));
        chk("hold_busy", busy, 1);
        chk("hold_data", res_data, res);
      end
      start = 0; res_ready = 1;
      @(posedge clk); #1;
      res_ready = 0;
    end
  endtask

  initial begin
    logic [OW-1:0] res;
    int fv, nv, nb, nr, nvl;
    for (int i = 0; i < (1 << AW); i++) begin
      img_ram[i] = IW'($urandom);
      wgt_ram[i] = IW'($urandom);
    end
    @(posedge clk); #1; chk_on = 1;
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;

    // small known dot product with ready held high
    img_ram[0] = 1; img_ram[1] = 2; img_ram[2] = 3;
    wgt_ram[0] = 4; wgt_ram[1] = 5; wgt_ram[2] = 6;
    run(3, 0, 0, 0, 1, res, fv, nv);
    chk("t1_result", res, 32);
    chk("t1_first_valid_cycle", fv, 8);
    chk("t1_valid_cycles", nv, 1);

    // full-scale len=64, back-to-back start
    for (int i = 0; i < 64; i++) begin img_ram[100 + i] = 8'd255; wgt_ram[200 + i] = 8'd255; end
    run(64, 100, 200, 0, 0, res, fv, nv);
    chk("t2_result", res, 4161600);

    // address wrap
    img_ram[1022] = 10; img_ram[1023] = 20; img_ram[0] = 30; img_ram[1] = 40;
    wgt_ram[500] = 1; wgt_ram[501] = 2; wgt_ram[502] = 3; wgt_ram[503] = 4;
    addr_q.delete(); log_en = 1;
    run(4, 1022, 500, 0, 0, res, fv, nv);
    log_en = 0;
    chk("t3_result", res, 300);
    chk("t3_nreads", addr_q.size(), 4);
    if (addr_q.size() == 4) begin
      chk("t3_addr0", addr_q[0], 1022);
      chk("t3_addr1", addr_q[1], 1023);
      chk("t3_addr2", addr_q[2], 0);
      chk("t3_addr3", addr_q[3], 1);
    end

    // long HOLD with ignored start pulses
    run(5, 300, 700, 10, 0, res, fv, nv);
    chk("t4_result", res, dot(5, 300, 700));

    // reset in cycle 4 of a len=8 run, then a fresh short run
    start = 1; len = 8; img_base = 10; wgt_base = 20;
    @(posedge clk); #1; start = 0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1; rst = 0;
    chk("t5_busy_after_rst", busy, 0);
    chk("t5_ac_after_rst", ac_mem_en, 0);
    img_ram[40] = 7; img_ram[41] = 7; wgt_ram[60] = 3; wgt_ram[61] = 3;
    run(2, 40, 60, 1, 0, res, fv, nv);
    chk("t5_result", res, 42);

    // len=0 start is ignored
    start = 1; len = 0; nb = 0; nr = 0; nvl = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1; start = 0;
      nb += int'(busy); nr += int'(rst_mem); nvl += int'(res_valid);
    end
    chk("t6_busy", nb, 0);
    chk("t6_rst_mem", nr, 0);
    chk("t6_valid", nvl, 0);

    // randomized transactions
    for (int t = 0; t < 12; t++) begin
      int n;
      logic [AW-1:0] ib, wb;
      n = $urandom_range(1, 127);
      ib = AW'($urandom); wb = AW'($urandom);
      run(n, ib, wb, $urandom_range(0, 3), 1'($urandom_range(0, 1)), res, fv, nv);
      chk("rand_result", res, dot(n, ib, wb));
      chk("rand_latency", fv, n + 5);
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
